// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
//
// Purpose:
//   Bundles the two requester ports of the instruction-ROM arbiter into a
//   single interface. Port 0 is the instruction fetch unit and port 1 is the
//   secondary reader (debug/loader or load-from-ROM path).
//
// Signals (direction seen from the arbiter, i.e. the slave modport):
//   i_req0, i_req1      in   1           access request, ports 0/1
//   i_addr0, i_addr1    in   ADDR_WIDTH  byte address, ports 0/1
//   o_gnt0, o_gnt1      out  1           grant, combinational, same cycle
//   o_rvalid0/1         out  1           read data valid, one-cycle pulse
//   o_rdata0/1          out  DATA_WIDTH  registered read data
//   o_err0/1            out  1           access error, qualified by o_rvalidN
//
// Modports:
//   master - requester side (drives requests, observes grants and returns)
//   slave  - arbiter side
// -----------------------------------------------------------------------------
`default_nettype none

interface imem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_req0;
    logic                  i_req1;
    logic [ADDR_WIDTH-1:0] i_addr0;
    logic [ADDR_WIDTH-1:0] i_addr1;
    logic                  o_gnt0;
    logic                  o_gnt1;
    logic                  o_rvalid0;
    logic                  o_rvalid1;
    logic [DATA_WIDTH-1:0] o_rdata0;
    logic [DATA_WIDTH-1:0] o_rdata1;
    logic                  o_err0;
    logic                  o_err1;

    modport master (
        output i_req0, i_req1, i_addr0, i_addr1,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1,
        input  o_rdata0, o_rdata1, o_err0, o_err1
    );

    modport slave (
        input  i_req0, i_req1, i_addr0, i_addr1,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1,
        output o_rdata0, o_rdata1, o_err0, o_err1
    );
endinterface

`default_nettype wire

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Purpose:
//   Two-port access controller in front of a single-read-port, combinational
//   instruction ROM. One ROM access is granted per cycle. Byte addresses are
//   converted to word indices and checked for alignment and range; the
//   granted port receives registered read data plus a one-cycle valid pulse
//   on the following cycle.
//
// Configuration macro:
//   IMEM_ARB_RR_EN  defined   -> round-robin arbitration (1-bit last_gnt)
//                   undefined -> fixed priority to port 0 with a MAX_WAIT
//                                anti-starvation counter for port 1
//
// Ports:
//   i_clk       in   1            clock, rising edge
//   i_rst_n     in   1            asynchronous active-low reset
//   bus         slave modport of imem_arbiter_if (requests, grants, returns)
//   o_rom_addr  out  ROM_AW       word index presented to the ROM
//   i_rom_data  in   DATA_WIDTH   combinational ROM output
// -----------------------------------------------------------------------------
`default_nettype none

module imem_arbiter #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    ROM_BLOCKS_NUM = 128,
    parameter logic [DATA_WIDTH-1:0] ROM_DEFLT_DATA = '0,
    parameter int                    MAX_WAIT       = 4,
    localparam int                   ROM_AW         = (ROM_BLOCKS_NUM > 1) ? $clog2(ROM_BLOCKS_NUM) : 1
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    imem_arbiter_if.slave              bus,
    output      logic [ROM_AW-1:0]     o_rom_addr,
    input  wire logic [DATA_WIDTH-1:0] i_rom_data
);

    // -------------------------------------------------------------------------
    // Address checking helper: misaligned or beyond the last ROM word.
    // The word index is zero-extended back to ADDR_WIDTH so the range compare
    // sees every address bit, not just the bits that reach the ROM.
    // -------------------------------------------------------------------------
    function automatic logic addr_is_bad(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word_idx;
        word_idx = {2'b00, addr[ADDR_WIDTH-1:2]};
        return (addr[1:0] != 2'b00) ||
               (word_idx >= ADDR_WIDTH'(ROM_BLOCKS_NUM));
    endfunction

    // -------------------------------------------------------------------------
    // Request qualification and address decode
    // -------------------------------------------------------------------------
    logic              req0_s;
    logic              req1_s;
    logic              bad0_s;
    logic              bad1_s;
    logic [ROM_AW-1:0] idx0_s;
    logic [ROM_AW-1:0] idx1_s;
    logic              gnt0_s;
    logic              gnt1_s;

    // Requests are masked while reset is asserted so that nothing is granted
    // and every output, including the combinational ones, reads 0 in reset.
    always_comb begin
        req0_s = bus.i_req0 & i_rst_n;
        req1_s = bus.i_req1 & i_rst_n;
        bad0_s = addr_is_bad(bus.i_addr0);
        bad1_s = addr_is_bad(bus.i_addr1);
        idx0_s = bus.i_addr0[ROM_AW+1:2];
        idx1_s = bus.i_addr1[ROM_AW+1:2];
    end

`ifdef IMEM_ARB_RR_EN
    // -------------------------------------------------------------------------
    // Round-robin arbitration. last_gnt_q holds the port granted most
    // recently; on contention the other port wins. Reset value 1 makes port 0
    // win the first contention after reset.
    // -------------------------------------------------------------------------
    logic last_gnt_q;
    logic last_gnt_d;

    // Grant selection: a lone requester always wins, contention alternates.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req0_s && req1_s) begin
            gnt0_s = last_gnt_q;
            gnt1_s = ~last_gnt_q;
        end else begin
            gnt0_s = req0_s;
            gnt1_s = req1_s;
        end
    end

    // Pointer next state: follows every grant, holds while idle.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt1_s) begin
            last_gnt_d = 1'b1;
        end else if (gnt0_s) begin
            last_gnt_d = 1'b0;
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    // -------------------------------------------------------------------------
    // Fixed-priority arbitration with anti-starvation. wait_q counts the
    // consecutive cycles port 1 has been requesting without a grant; once it
    // reaches MAX_WAIT, port 1 overrides port 0 for one grant.
    // -------------------------------------------------------------------------
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_SAT_C = 4'hF;

    logic [3:0] wait_q;
    logic [3:0] wait_d;
    logic       starve_s;

    // Grant selection: port 0 by default, port 1 when alone or starved.
    always_comb begin
        starve_s = req1_s && (wait_q == MAX_WAIT_C);
        gnt1_s   = req1_s && (!req0_s || starve_s);
        gnt0_s   = req0_s && !gnt1_s;
    end

    // Wait counter next state: clear on grant or withdrawal, else saturate up.
    always_comb begin
        wait_d = wait_q;
        if (!req1_s || gnt1_s) begin
            wait_d = 4'h0;
        end else if (wait_q != WAIT_SAT_C) begin
            wait_d = wait_q + 4'h1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Wait counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_q <= 4'h0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // ROM address: granted word index, 0 when the ROM is not being accessed.
    // -------------------------------------------------------------------------
    logic [ROM_AW-1:0] rom_addr_s;

    // ROM address mux.
    always_comb begin
        rom_addr_s = {ROM_AW{1'b0}};
        if (gnt0_s) begin
            rom_addr_s = idx0_s;
        end else if (gnt1_s) begin
            rom_addr_s = idx1_s;
        end else begin
            rom_addr_s = {ROM_AW{1'b0}};
        end
    end

    // -------------------------------------------------------------------------
    // Return path. Only the granted port's registers load; the other port's
    // data holds while its valid and error flags drop to 0. An erroneous
    // access returns ROM_DEFLT_DATA and never samples the ROM output.
    // -------------------------------------------------------------------------
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  err0_q,    err0_d;
    logic                  err1_q,    err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q,  rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q,  rdata1_d;

    // Port 0 return next state.
    always_comb begin
        rvalid0_d = gnt0_s;
        err0_d    = gnt0_s & bad0_s;
        rdata0_d  = rdata0_q;
        if (gnt0_s) begin
            if (bad0_s) begin
                rdata0_d = ROM_DEFLT_DATA;
            end else begin
                rdata0_d = i_rom_data;
            end
        end else begin
            rdata0_d = rdata0_q;
        end
    end

    // Port 1 return next state.
    always_comb begin
        rvalid1_d = gnt1_s;
        err1_d    = gnt1_s & bad1_s;
        rdata1_d  = rdata1_q;
        if (gnt1_s) begin
            if (bad1_s) begin
                rdata1_d = ROM_DEFLT_DATA;
            end else begin
                rdata1_d = i_rom_data;
            end
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // Return path registers; reset drops any access granted in the last cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= {DATA_WIDTH{1'b0}};
            rdata1_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign bus.o_gnt0    = gnt0_s;
    assign bus.o_gnt1    = gnt1_s;
    assign bus.o_rvalid0 = rvalid0_q;
    assign bus.o_rvalid1 = rvalid1_q;
    assign bus.o_err0    = err0_q;
    assign bus.o_err1    = err1_q;
    assign bus.o_rdata0  = rdata0_q;
    assign bus.o_rdata1  = rdata1_q;
    assign o_rom_addr    = rom_addr_s;

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Self-checking bench for imem_arbiter. Inputs change 1 time unit after the
// rising edge; combinational outputs are sampled at the falling edge and
// registered outputs 1 time unit after the next rising edge. Expected values
// come from directed constants and from a reference model that applies the
// arbitration rules to the requests of each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imem_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NB   = 128;
    localparam int RAW  = 7;
    localparam int MAXW = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    imem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [RAW-1:0] o_rom_addr;
    logic [DW-1:0]  i_rom_data;
    logic [DW-1:0]  rom_mem [NB];

    assign i_rom_data = rom_mem[o_rom_addr];

    imem_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .ROM_BLOCKS_NUM (NB),
        .ROM_DEFLT_DATA ({DW{1'b0}}),
        .MAX_WAIT       (MAXW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .bus        (bus),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model state ----------------
    bit             m_g0, m_g1;
    logic [RAW-1:0] m_rom_addr;
    bit             m_rvalid0, m_rvalid1, m_err0, m_err1;
    logic [DW-1:0]  m_rdata0, m_rdata1;
    int             m_next_winner;   // port that wins the next contention
    int             m_refused;       // cycles port 1 has waited

    function automatic bit is_err(input logic [AW-1:0] a);
        longint unsigned word;
        word = longint'(a) / 4;
        return (a % 4 != 0) || (word >= NB);
    endfunction

    function automatic logic [RAW-1:0] word_of(input logic [AW-1:0] a);
        return RAW'((longint'(a) / 4) % NB);
    endfunction

    task automatic model_clear();
        m_g0 = 0; m_g1 = 0; m_rom_addr = '0;
        m_rvalid0 = 0; m_rvalid1 = 0; m_err0 = 0; m_err1 = 0;
        m_rdata0 = '0; m_rdata1 = '0;
        m_next_winner = 0;
        m_refused = 0;
    endtask

    task automatic model_cycle(input bit r0, input logic [AW-1:0] a0,
                               input bit r1, input logic [AW-1:0] a1);
        m_g0 = 0; m_g1 = 0;
        if (r0 && r1) begin
`ifdef IMEM_ARB_RR_EN
            if (m_next_winner == 0) m_g0 = 1; else m_g1 = 1;
`else
            if (m_refused == MAXW) m_g1 = 1; else m_g0 = 1;
`endif
        end else begin
            m_g0 = r0;
            m_g1 = r1;
        end
`ifdef IMEM_ARB_RR_EN
        if (m_g0) m_next_winner = 1;
        else if (m_g1) m_next_winner = 0;
`else
        if (!r1 || m_g1) m_refused = 0;
        else if (m_refused < 15) m_refused = m_refused + 1;
`endif
        m_rom_addr = m_g0 ? word_of(a0) : (m_g1 ? word_of(a1) : '0);
        m_rvalid0 = m_g0;
        m_rvalid1 = m_g1;
        m_err0 = m_g0 && is_err(a0);
        m_err1 = m_g1 && is_err(a1);
        if (m_g0) m_rdata0 = is_err(a0) ? '0 : rom_mem[word_of(a0)];
        if (m_g1) m_rdata1 = is_err(a1) ? '0 : rom_mem[word_of(a1)];
    endtask

    // ---------------- stimulus plumbing (no checks) ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Apply one cycle of requests, advance the model, stop at the falling edge.
    task automatic drive(input bit r0, input logic [AW-1:0] a0,
                         input bit r1, input logic [AW-1:0] a1);
        bus.i_req0 = r0; bus.i_addr0 = a0;
        bus.i_req1 = r1; bus.i_addr1 = a1;
        model_cycle(r0, a0, r1, a1);
        #4;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        bus.i_req0 = 0; bus.i_req1 = 0; bus.i_addr0 = '0; bus.i_addr1 = '0;
        model_clear();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        bus.i_req0 = 1; bus.i_addr0 = 32'h8;
        bus.i_req1 = 1; bus.i_addr1 = 32'hC;
        #2;
        vectors++; if (bus.o_gnt0 !== 1'b0 || bus.o_gnt1 !== 1'b0) begin miscompares++;
            $display("FAIL reset_gnt: got %b%b expected 00", bus.o_gnt0, bus.o_gnt1); end
        vectors++; if (o_rom_addr !== 7'd0) begin miscompares++;
            $display("FAIL reset_rom_addr: got %0d expected 0", o_rom_addr); end
        vectors++; if ({bus.o_rvalid0, bus.o_rvalid1, bus.o_err0, bus.o_err1} !== 4'b0000) begin miscompares++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.o_rvalid0, bus.o_rvalid1, bus.o_err0, bus.o_err1}); end
        vectors++; if (bus.o_rdata0 !== 32'h0 || bus.o_rdata1 !== 32'h0) begin miscompares++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.o_rdata0, bus.o_rdata1); end
        do_reset();
    endtask

    task automatic test_single_fetch();
        drive(1, 32'h0000_0008, 0, '0);
        vectors++; if (bus.o_gnt0 !== 1'b1 || bus.o_gnt1 !== 1'b0) begin miscompares++;
            $display("FAIL fetch_gnt: got %b%b expected 10", bus.o_gnt0, bus.o_gnt1); end
        vectors++; if (o_rom_addr !== 7'd2) begin miscompares++;
            $display("FAIL fetch_rom_addr: got %0d expected 2", o_rom_addr); end
        tick();
        vectors++; if (bus.o_rvalid0 !== 1'b1 || bus.o_rvalid1 !== 1'b0 || bus.o_err0 !== 1'b0) begin miscompares++;
            $display("FAIL fetch_valid: got rv0=%b rv1=%b err0=%b expected 1 0 0", bus.o_rvalid0, bus.o_rvalid1, bus.o_err0); end
        vectors++; if (bus.o_rdata0 !== 32'hDEADBEEF) begin miscompares++;
            $display("FAIL fetch_rdata: got %h expected deadbeef", bus.o_rdata0); end
        drive(0, '0, 0, '0);
        tick();
        vectors++; if (bus.o_rvalid0 !== 1'b0 || bus.o_rdata0 !== 32'hDEADBEEF) begin miscompares++;
            $display("FAIL fetch_hold: got rv0=%b rdata0=%h expected 0 deadbeef", bus.o_rvalid0, bus.o_rdata0); end
    endtask

    task automatic test_errors();
        logic [AW-1:0] bad_addr [2];
        bad_addr[0] = 32'h0000_0006;
        bad_addr[1] = 32'h0000_0200;
        for (int k = 0; k < 2; k++) begin
            drive(0, '0, 1, 32'h0000_000C);   // load nonzero data first
            tick();
            vectors++; if (bus.o_rdata1 !== 32'h1234_5678) begin miscompares++;
                $display("FAIL err_pre_rdata%0d: got %h expected 12345678", k, bus.o_rdata1); end
            drive(0, '0, 1, bad_addr[k]);
            vectors++; if (bus.o_gnt1 !== 1'b1) begin miscompares++;
                $display("FAIL err_gnt%0d: got %b expected 1", k, bus.o_gnt1); end
            tick();
            vectors++; if (bus.o_rvalid1 !== 1'b1 || bus.o_err1 !== 1'b1 || bus.o_rdata1 !== 32'h0) begin miscompares++;
                $display("FAIL err_resp%0d: got rv1=%b err1=%b rdata1=%h expected 1 1 0", k, bus.o_rvalid1, bus.o_err1, bus.o_rdata1); end
            vectors++; if (bus.o_rdata0 !== m_rdata0 || bus.o_err0 !== 1'b0) begin miscompares++;
                $display("FAIL err_other%0d: got rdata0=%h err0=%b expected %h 0", k, bus.o_rdata0, bus.o_err0, m_rdata0); end
        end
        drive(0, '0, 0, '0);
        tick();
    endtask

    task automatic test_contention();
`ifdef IMEM_ARB_RR_EN
        localparam int N = 4;
        logic [N-1:0] seq = 4'b1010;            // bit i: port 1 granted in cycle i
`else
        localparam int N = 10;
        logic [N-1:0] seq = 10'b10_0001_0000;   // port 1 at cycles 4 and 9
`endif
        do_reset();
        for (int i = 0; i < N; i++) begin
            drive(1, AW'(4 * i), 1, AW'(4 * (i + 20)));
            vectors++; if (bus.o_gnt1 !== seq[i] || bus.o_gnt0 !== !seq[i]) begin miscompares++;
                $display("FAIL cont_gnt cycle %0d: got %b%b expected %b%b", i, bus.o_gnt0, bus.o_gnt1, !seq[i], seq[i]); end
            tick();
            vectors++; if (bus.o_rvalid1 !== seq[i] || bus.o_rvalid0 !== !seq[i]) begin miscompares++;
                $display("FAIL cont_rvalid cycle %0d: got %b%b expected %b%b", i, bus.o_rvalid0, bus.o_rvalid1, !seq[i], seq[i]); end
            vectors++; if (bus.o_rdata0 !== m_rdata0 || bus.o_rdata1 !== m_rdata1) begin miscompares++;
                $display("FAIL cont_rdata cycle %0d: got %h/%h expected %h/%h", i, bus.o_rdata0, bus.o_rdata1, m_rdata0, m_rdata1); end
        end
        drive(0, '0, 0, '0);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h0000_0008, 0, '0);
        vectors++; if (bus.o_gnt0 !== 1'b1) begin miscompares++;
            $display("FAIL rmid_gnt: got %b expected 1", bus.o_gnt0); end
        #1 i_rst_n = 1'b0;
        #1;
        vectors++; if ({bus.o_gnt0, bus.o_gnt1, bus.o_rvalid0, bus.o_rvalid1, bus.o_err0, bus.o_err1} !== 6'b0) begin miscompares++;
            $display("FAIL rmid_flags: got %b expected 000000", {bus.o_gnt0, bus.o_gnt1, bus.o_rvalid0, bus.o_rvalid1, bus.o_err0, bus.o_err1}); end
        vectors++; if (bus.o_rdata0 !== 32'h0 || bus.o_rdata1 !== 32'h0 || o_rom_addr !== 7'd0) begin miscompares++;
            $display("FAIL rmid_data: got %h/%h rom_addr %0d expected 0/0 0", bus.o_rdata0, bus.o_rdata1, o_rom_addr); end
        bus.i_req0 = 0; bus.i_req1 = 0;
        model_clear();
        #1 i_rst_n = 1'b1;
        tick();
        vectors++; if (bus.o_rvalid0 !== 1'b0 || bus.o_rdata0 !== 32'h0) begin miscompares++;
            $display("FAIL rmid_rvalid: got rv0=%b rdata0=%h expected 0 0", bus.o_rvalid0, bus.o_rdata0); end
    endtask

    task automatic test_withdrawal();
        do_reset();
        drive(1, 32'h10, 1, 32'h14);
        vectors++; if (bus.o_gnt0 !== 1'b1 || bus.o_gnt1 !== 1'b0) begin miscompares++;
            $display("FAIL wd_gnt_a: got %b%b expected 10", bus.o_gnt0, bus.o_gnt1); end
        tick();
        drive(1, 32'h18, 0, 32'h14);
        vectors++; if (bus.o_gnt1 !== 1'b0) begin miscompares++;
            $display("FAIL wd_gnt_b: got %b expected 0", bus.o_gnt1); end
        tick();
        vectors++; if (bus.o_rvalid1 !== 1'b0 || bus.o_rvalid0 !== 1'b1) begin miscompares++;
            $display("FAIL wd_rvalid: got %b%b expected 10", bus.o_rvalid0, bus.o_rvalid1); end
        drive(0, '0, 0, '0);
        tick();
`ifdef IMEM_ARB_RR_EN
        drive(1, 32'h20, 1, 32'h24);   // port 0 went last, so port 1 wins
        vectors++; if (bus.o_gnt1 !== 1'b1) begin miscompares++;
            $display("FAIL wd_rr_next: got %b expected 1", bus.o_gnt1); end
        tick();
`else
        // A cleared counter means port 1 loses exactly MAXW contentions again.
        for (int i = 0; i <= MAXW; i++) begin
            drive(1, 32'h20, 1, 32'h24);
            vectors++; if (bus.o_gnt1 !== (i == MAXW)) begin miscompares++;
                $display("FAIL wd_wait cycle %0d: got %b expected %b", i, bus.o_gnt1, (i == MAXW)); end
            tick();
        end
`endif
        drive(0, '0, 0, '0);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(1, AW'(4 * (i + 40)), 0, '0);
            tick();
            vectors++; if (bus.o_rvalid0 !== 1'b1 || bus.o_rdata0 !== rom_mem[i + 40]) begin miscompares++;
                $display("FAIL b2b cycle %0d: got rv0=%b rdata0=%h expected 1 %h", i, bus.o_rvalid0, bus.o_rdata0, rom_mem[i + 40]); end
        end
        drive(0, '0, 0, '0);
        tick();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 8) return AW'($urandom_range(0, NB - 1) * 4 + $urandom_range(1, 3));
        if (kind == 9) return AW'($urandom_range(NB, NB + 300) * 4);
        return AW'($urandom_range(0, NB - 1) * 4);
    endfunction

    task automatic test_random();
        bit r0, r1;
        logic [AW-1:0] a0, a1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            a0 = rand_addr();
            a1 = rand_addr();
            drive(r0, a0, r1, a1);
            vectors++; if (bus.o_gnt0 !== m_g0 || bus.o_gnt1 !== m_g1) begin miscompares++;
                $display("FAIL rnd_gnt cycle %0d: got %b%b expected %b%b", i, bus.o_gnt0, bus.o_gnt1, m_g0, m_g1); end
            vectors++; if (o_rom_addr !== m_rom_addr) begin miscompares++;
                $display("FAIL rnd_rom_addr cycle %0d: got %0d expected %0d", i, o_rom_addr, m_rom_addr); end
            tick();
            vectors++; if ({bus.o_rvalid0, bus.o_rvalid1, bus.o_err0, bus.o_err1} !== {m_rvalid0, m_rvalid1, m_err0, m_err1}) begin miscompares++;
                $display("FAIL rnd_flags cycle %0d: got %b expected %b", i, {bus.o_rvalid0, bus.o_rvalid1, bus.o_err0, bus.o_err1}, {m_rvalid0, m_rvalid1, m_err0, m_err1}); end
            vectors++; if (bus.o_rdata0 !== m_rdata0 || bus.o_rdata1 !== m_rdata1) begin miscompares++;
                $display("FAIL rnd_rdata cycle %0d: got %h/%h expected %h/%h", i, bus.o_rdata0, bus.o_rdata1, m_rdata0, m_rdata1); end
        end
    endtask

    initial begin
        for (int i = 0; i < NB; i++) rom_mem[i] = $urandom;
        rom_mem[2] = 32'hDEADBEEF;
        rom_mem[3] = 32'h1234_5678;
        model_clear();
        test_reset();
        test_single_fetch();
        test_errors();
        test_contention();
        test_reset_mid();
        test_withdrawal();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port access controller for the single-read-port instruction ROM. Port 0 is the instruction fetch unit. Port 1 is a secondary reader, such as the debug/loader path or load-from-ROM. The block arbitrates one ROM access per cycle, converts byte addresses to word indices, range- and alignment-checks them, and returns registered read data with a per-port valid pulse. It sits between the fetch/debug masters and the combinational instruction ROM.

## Interface

Parameters:
- DATA_WIDTH, 32, ROM word width
- ADDR_WIDTH, 32, requester byte-address width
- ROM_BLOCKS_NUM, 128, ROM depth in words
- ROM_DEFLT_DATA, all zeros, data returned on an erroneous access
- MAX_WAIT, 4, maximum number of consecutive cycles port 1 may be refused a grant while requesting (fixed-priority build only, range 1..15)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req0, i_req1  in  1  access request, ports 0/1
- i_addr0, i_addr1  in  ADDR_WIDTH  byte address, ports 0/1
- o_gnt0, o_gnt1  out  1  grant, combinational, same cycle as the request
- o_rvalid0, o_rvalid1  out  1  read data valid, registered, one-cycle pulse
- o_rdata0, o_rdata1  out  DATA_WIDTH  read data, registered
- o_err0, o_err1  out  1  access error, qualified by o_rvalidN
- o_rom_addr  out  $clog2(ROM_BLOCKS_NUM)  word index to the ROM
- i_rom_data  in  DATA_WIDTH  combinational ROM output

## Operation

- **Handshake**
  - A requester asserts i_reqN with i_addrN.
  - It holds both stable until it sees o_gntN=1. The access completes in that cycle.
  - Dropping i_reqN before the grant is legal. It withdraws the request.
- **Grant rules**
  - At most one of o_gnt0/o_gnt1 is high in any cycle.
  - A grant is issued whenever at least one request is present. The arbiter never idles while a request is pending.
- **Address handling**
  - Word index = addrN[ADDR_WIDTH-1:2].
  - The access is an error if addrN[1:0] != 0 or the index is >= ROM_BLOCKS_NUM.
  - On error: o_rdataN = ROM_DEFLT_DATA and o_errN = 1. No ROM data is captured.
- **ROM address**
  - o_rom_addr = granted index, truncated to its width.
  - When nothing is granted, o_rom_addr is 0.
- **Return path**
  - The granted port's rvalid, rdata and err registers load on the edge that ends the grant cycle.
  - The other port's rdata holds its last value. Its rvalid and err are 0.
- **Arbitration state**
  - Round-robin build: 1-bit last_gnt pointer.
  - Fixed-priority build: wait counter (4 bits).

## Timing

- **Reset (asynchronous)**
  - All of o_rvalid0/1, o_err0/1 = 0. o_rdata0/1 = 0.
  - last_gnt = 1, so port 0 wins the first contention.
  - Wait counter = 0.
- **Latency**
  - Request in cycle N with grant in N gives o_rvalidN=1 in cycle N+1.
  - Back-to-back grants to the same port yield rvalid high on consecutive cycles. Throughput is one access per cycle.
- **Single requester**
  - It is granted in the cycle it requests, regardless of pointer or counter state.
  - Pointer and counter still update as specified below.
- **Reset mid-access**
  - A grant in cycle N with reset asserted before edge N+1 produces no rvalid.
  - The requester must re-request after reset deasserts.
- **Round-robin build**
  - When both ports request, grant the port != last_gnt.
  - last_gnt is updated to the granted port on every grant. It holds when idle.
- **Fixed-priority build**
  - Port 0 wins contention.
  - The counter increments each cycle that i_req1=1 and o_gnt1=0. It saturates at 15.
  - It clears on o_gnt1 or on !i_req1.
  - When counter == MAX_WAIT and i_req1=1, port 1 is granted even if port 0 requests.

## Configuration

- **IMEM_ARB_RR_EN**
  - Defined: round-robin arbitration using last_gnt. The wait counter and MAX_WAIT are not implemented.
  - Undefined: fixed priority to port 0, with the MAX_WAIT anti-starvation counter. last_gnt is not implemented, and reset priority is port 0.

## Test plan

- **Single fetch:** after reset, i_req0=1 with i_addr0=0x0000_0008 and rom[2]=0xDEADBEEF -> o_gnt0=1 and o_rom_addr=2 that cycle; next cycle o_rvalid0=1, o_rdata0=0xDEADBEEF, o_err0=0.
- **Errors:** i_addr1=0x0000_0006 -> o_rvalid1=1, o_err1=1, o_rdata1=0. Separately, i_addr1=0x0000_0200 (index 128) -> same response.
- **Round-robin contention (RR_EN):** both ports request continuously for 4 cycles -> grant sequence 0,1,0,1; rvalid alternates accordingly one cycle later.
- **Starvation cap (no RR_EN, MAX_WAIT=4):** both request continuously -> grants 0,0,0,0,1,0,0,0,0,1; counter clears after each port-1 grant.
- **Reset mid-access:** grant port 0, then pulse i_rst_n low before the next edge -> o_rvalid0 stays 0; all outputs read 0 during reset.
- **Withdrawal:** port 1 requests, loses to port 0, then drops i_req1 -> no o_gnt1 and no o_rvalid1; wait counter returns to 0.
